// File: rtl/ftdi_host_iface.sv
// FT245-mode FIFO bridge: parses 8-byte host register commands onto the tri-state
// register bus, replies with 5 bytes, and streams output-mux bytes when idle.
module ftdi_host_iface #(
   parameter int          N_OMUX      = 1,
   parameter int          RD_CYCLES   = 3,
   parameter int          WR_CYCLES   = 3,
   parameter logic [7:0]  CMD_MAGIC   = 8'hAA,
   parameter logic [7:0]  REPLY_MAGIC = 8'hAB
)(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              nrxf_i,
   input  logic              ntxe_i,
   output logic              nrd_o,
   output logic              wr_o,
   output logic              si_o,
   inout  wire  [7:0]        d_io,
   input  logic [7:0]        omux_data_i,
   output logic [N_OMUX-1:0] omux_sel_o,
   input  logic [N_OMUX-1:0] omux_req_i,
   output logic [15:0]       reg_addr_o,
   inout  wire  [31:0]       reg_data_io,
   output logic              reg_wr_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_RECOVER, S_C1, S_C2, S_C3, S_MUX,
      S_TX_WAIT, S_TX_SETUP, S_TX_WR, S_TX_HOLD, S_SI
   } state_t;

   state_t            state, state_n;
   logic [1:0]        nrxf_sync, ntxe_sync;
   logic              nrxf_s, ntxe_s;
   logic [7:0]        cnt;
   logic [2:0]        byte_cnt;
   logic              wr_flag, cmd_done, in_reply;
   logic [15:0]       addr;
   logic [31:0]       value, rd_val;
   logic [2:0]        tx_idx;
   logic [7:0]        tx_q, mux_byte, reply_byte;
   logic [N_OMUX-1:0] sel_q, req_low;
   logic              d_oe, rd_last;

   assign nrxf_s  = nrxf_sync[1];
   assign ntxe_s  = ntxe_sync[1];
   assign rd_last = (state == S_RD) && (cnt == 8'(RD_CYCLES - 1));
   // Two's-complement trick isolates the lowest requesting source.
   assign req_low = omux_req_i & (~omux_req_i + N_OMUX'(1));

   always_comb begin
      case (tx_idx)
         3'd0:    reply_byte = REPLY_MAGIC;
         3'd1:    reply_byte = rd_val[7:0];
         3'd2:    reply_byte = rd_val[15:8];
         3'd3:    reply_byte = rd_val[23:16];
         default: reply_byte = rd_val[31:24];
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= S_IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:     if (!nrxf_s)                         state_n = S_RD;
                     else if ((|omux_req_i) && !ntxe_s)   state_n = S_MUX;
         S_RD:       if (rd_last)                         state_n = S_RECOVER;
         S_RECOVER:  if (cnt == 8'd2)                     state_n = cmd_done ? S_C1 : S_IDLE;
         S_C1:                                            state_n = S_C2;
         S_C2:                                            state_n = S_C3;
         S_C3:                                            state_n = S_TX_WAIT;
         S_MUX:                                           state_n = S_TX_WAIT;
         S_TX_WAIT:  if (!ntxe_s)                         state_n = S_TX_SETUP;
         S_TX_SETUP:                                      state_n = S_TX_WR;
         S_TX_WR:    if (cnt == 8'(WR_CYCLES - 1))        state_n = S_TX_HOLD;
         S_TX_HOLD:  if (!in_reply)                       state_n = S_IDLE;
                     else if (tx_idx == 3'd4)             state_n = S_SI;
                     else                                 state_n = S_TX_WAIT;
         S_SI:       if (cnt == 8'd1)                     state_n = S_IDLE;
         default:                                         state_n = S_IDLE;
      endcase
   end

   always_comb begin
      nrd_o      = (state != S_RD);
      wr_o       = (state == S_TX_WR);
      si_o       = (state != S_SI);
      d_oe       = (state == S_TX_SETUP) || (state == S_TX_WR) || (state == S_TX_HOLD);
      reg_wr_o   = (state == S_C1) && wr_flag;
      omux_sel_o = (state == S_MUX) ? sel_q : '0;
   end

   assign d_io        = d_oe ? tx_q : 8'hzz;
   assign reg_data_io = reg_wr_o ? value : 32'hzzzz_zzzz;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         nrxf_sync  <= 2'b11;
         ntxe_sync  <= 2'b11;
         cnt        <= '0;
         byte_cnt   <= '0;
         wr_flag    <= 1'b0;
         cmd_done   <= 1'b0;
         in_reply   <= 1'b0;
         addr       <= '0;
         value      <= '0;
         rd_val     <= '0;
         tx_idx     <= '0;
         tx_q       <= '0;
         mux_byte   <= '0;
         sel_q      <= '0;
         reg_addr_o <= '0;
      end else begin
         nrxf_sync <= {nrxf_sync[0], nrxf_i};
         ntxe_sync <= {ntxe_sync[0], ntxe_i};
         cnt       <= (state_n != state) ? 8'd0 : cnt + 8'd1;
         if (rd_last) begin
            if (byte_cnt == 3'd0) begin
               if (d_io == CMD_MAGIC) byte_cnt <= 3'd1;
            end else begin
               case (byte_cnt)
                  3'd1:    wr_flag       <= d_io[0];
                  3'd2:    addr[7:0]     <= d_io;
                  3'd3:    addr[15:8]    <= d_io;
                  3'd4:    value[7:0]    <= d_io;
                  3'd5:    value[15:8]   <= d_io;
                  3'd6:    value[23:16]  <= d_io;
                  default: value[31:24]  <= d_io;
               endcase
               byte_cnt <= byte_cnt + 3'd1;
               if (byte_cnt == 3'd7) cmd_done <= 1'b1;
            end
         end
         if (state_n == S_C1) reg_addr_o <= addr;
         if (state == S_C1)   cmd_done   <= 1'b0;
         if (state == S_C3) begin
            rd_val   <= reg_data_io;
            in_reply <= 1'b1;
            tx_idx   <= 3'd0;
         end
         if (state == S_SI) in_reply <= 1'b0;
         if (state == S_TX_HOLD && in_reply) tx_idx <= tx_idx + 3'd1;
         if (state_n == S_MUX) sel_q <= req_low;
         if (state == S_MUX)   mux_byte <= omux_data_i;
         if (state_n == S_TX_SETUP) tx_q <= in_reply ? reply_byte : mux_byte;
      end
   end

endmodule

// File: tb/tb_ftdi_host_iface.sv
// Bench for ftdi_host_iface: host FIFO model, register slaves and two mux sources,
// with reply/stream bytes checked against a queue of expected bytes.
module tb_ftdi_host_iface;
   localparam int NM = 2;
   localparam int RDC = 3;
   localparam int WRC = 3;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic          nrxf_i = 1'b1, ntxe_i = 1'b0;
   wire           nrd_o, wr_o, si_o, reg_wr_o;
   wire  [7:0]    d_io;
   logic [7:0]    omux_data;
   wire  [NM-1:0] omux_sel;
   logic [NM-1:0] omux_req;
   wire  [15:0]   reg_addr;
   wire  [31:0]   reg_data;

   ftdi_host_iface #(.N_OMUX(NM), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
      .clk_i(clk), .reset_i(rst), .nrxf_i(nrxf_i), .ntxe_i(ntxe_i),
      .nrd_o(nrd_o), .wr_o(wr_o), .si_o(si_o), .d_io(d_io),
      .omux_data_i(omux_data), .omux_sel_o(omux_sel), .omux_req_i(omux_req),
      .reg_addr_o(reg_addr), .reg_data_io(reg_data), .reg_wr_o(reg_wr_o)
   );

   int n_vec = 0, n_err = 0;
   logic [7:0] host_q[$];
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] cur = 8'h00;

   // host FIFO: byte presented while nrd low, consumed on nrd rising
   assign d_io = nrd_o ? 8'hzz : cur;
   always @(negedge nrd_o) cur = (host_q.size() > 0) ? host_q[0] : 8'h00;
   always @(posedge nrd_o) if (host_q.size() > 0) void'(host_q.pop_front());
   always @(negedge clk) nrxf_i = (host_q.size() == 0);

   // register slaves; unclaimed addresses read as the pull-down value 0
   logic [31:0] r1, r3, slave_rd;
   always @(posedge clk or posedge rst) begin
      if (rst) begin r1 <= 32'h0; r3 <= 32'h0; end
      else begin
         r3 <= r3 + 32'd1;
         if (reg_wr_o && reg_addr == 16'h0001) r1 <= reg_data;
         if (reg_wr_o && reg_addr == 16'h0003) r3 <= 32'h0;
      end
   end
   always_comb begin
      case (reg_addr)
         16'h0001: slave_rd = r1;
         16'h0002: slave_rd = 32'hFEEDBEEF;
         16'h0003: slave_rd = r3;
         default:  slave_rd = 32'h0;
      endcase
   end
   assign reg_data = reg_wr_o ? 32'hzzzz_zzzz : slave_rd;

   // mux sources
   logic [7:0] src_mem [NM][32];
   int src_len [NM];
   int src_idx [NM];
   initial for (int k = 0; k < NM; k++) begin src_len[k] = 0; src_idx[k] = 0; end
   always @(posedge clk) for (int k = 0; k < NM; k++) if (omux_sel[k]) src_idx[k] <= src_idx[k] + 1;
   always_comb begin
      omux_data = 8'h00;
      for (int k = 0; k < NM; k++) begin
         omux_req[k] = src_idx[k] < src_len[k];
         if (omux_sel[k] && src_idx[k] < 32) omux_data = src_mem[k][src_idx[k]];
      end
   end

   // strobe monitors
   int wr_run = 0, nrd_run = 0, si_run = 0, sel_run = 0;
   int wr_bad = 0, nrd_bad = 0, si_bad = 0, sel_bad = 0, overlap = 0, stab_bad = 0, hold_bad = 0;
   int si_pulses = 0, wr_pulses = 0, sel_pulses = 0;
   logic [7:0] rise_byte, hold_byte;
   bit hold_pend = 0;
   always @(posedge wr_o) rise_byte = d_io;
   always @(negedge wr_o) if (!rst) begin
      obs_q.push_back(d_io);
      if (d_io !== rise_byte) stab_bad++;
      hold_byte = d_io; hold_pend = 1;
   end
   always @(negedge clk) begin
      if (hold_pend) begin if (d_io !== hold_byte) hold_bad++; hold_pend = 0; end
      if (rst) begin wr_run = 0; nrd_run = 0; si_run = 0; sel_run = 0; end
      else begin
         if (wr_o && !nrd_o) overlap++;
         if (wr_o) wr_run++;
         else if (wr_run != 0) begin if (wr_run != WRC) wr_bad++; wr_pulses++; wr_run = 0; end
         if (!nrd_o) nrd_run++;
         else if (nrd_run != 0) begin if (nrd_run != RDC) nrd_bad++; nrd_run = 0; end
         if (!si_o) si_run++;
         else if (si_run != 0) begin if (si_run != 2) si_bad++; si_pulses++; si_run = 0; end
         if (|omux_sel) sel_run++;
         else if (sel_run != 0) begin if (sel_run != 1) sel_bad++; sel_pulses++; sel_run = 0; end
         if ($countones(omux_sel) > 1) sel_bad++;
      end
   end

   task automatic push_cmd(input logic [63:0] c);
      for (int i = 0; i < 8; i++) host_q.push_back(c[63-8*i -: 8]);
   endtask

   task automatic push_reply(input logic [31:0] v);
      exp_q.push_back(8'hAB);
      for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
   endtask

   task automatic wait_obs(input int n, output bit ok);
      int t = 0;
      while (obs_q.size() < n && t < 4000) begin @(negedge clk); t++; end
      ok = (obs_q.size() >= n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (nrd_o !== 1'b1) begin n_err++; $display("FAIL reset_nrd got %b want 1", nrd_o); end
      n_vec++; if (wr_o !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", wr_o); end
      n_vec++; if (si_o !== 1'b1) begin n_err++; $display("FAIL reset_si got %b want 1", si_o); end
      n_vec++; if (omux_sel !== '0) begin n_err++; $display("FAIL reset_sel got %b want 0", omux_sel); end
      n_vec++; if (reg_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr got %h want 0000", reg_addr); end
      n_vec++; if (reg_wr_o !== 1'b0) begin n_err++; $display("FAIL reset_regwr got %b want 0", reg_wr_o); end
   endtask

   task automatic test_reg_cmds();
      bit ok;
      int n, si0;
      logic [7:0] o, e;
      si0 = si_pulses;
      push_cmd(64'hAA_01_01_00_EF_BE_AD_DE); push_reply(32'hDEADBEEF);
      push_cmd(64'hAA_01_01_00_FF_FF_00_00); push_reply(32'h0000FFFF);
      push_cmd(64'hAA_01_02_00_44_33_22_11); push_reply(32'hFEEDBEEF);
      push_cmd(64'hAA_00_02_00_00_00_00_00); push_reply(32'hFEEDBEEF);
      push_cmd(64'hAA_00_01_00_12_34_56_78); push_reply(32'h0000FFFF);
      host_q.push_back(8'h55);
      push_cmd(64'hAA_01_10_00_78_56_34_12); push_reply(32'h00000000);
      n = exp_q.size();
      wait_obs(n, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL reg_cmds_timeout got %0d bytes want %0d", obs_q.size(), n); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_vec++; if (o !== e) begin n_err++; $display("FAIL reg_cmds_byte got %h want %h", o, e); end
      end
      repeat (8) @(negedge clk);
      n_vec++; if (si_pulses !== si0 + 6) begin n_err++; $display("FAIL si_pulse_count got %0d want %0d", si_pulses - si0, 6); end
      n_vec++; if (r1 !== 32'h0000FFFF) begin n_err++; $display("FAIL reg1_value got %h want 0000ffff", r1); end
   endtask

   task automatic test_counter();
      bit ok;
      logic [31:0] v;
      logic [7:0] m;
      obs_q.delete();
      push_cmd(64'hAA_00_03_00_00_00_00_00);
      wait_obs(5, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL cnt_read_timeout got %0d want 5", obs_q.size()); end
      m = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = (obs_q.size() > 0) ? obs_q.pop_front() : 8'h00;
      n_vec++; if (m !== 8'hAB) begin n_err++; $display("FAIL cnt_read_magic got %h want ab", m); end
      n_vec++; if (v === 32'h0) begin n_err++; $display("FAIL cnt_read_nonzero got %h want nonzero", v); end
      push_cmd(64'hAA_01_03_00_00_00_00_00);
      wait_obs(5, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL cnt_wr_timeout got %0d want 5", obs_q.size()); end
      m = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hFF;
      n_vec++; if (m !== 8'hAB) begin n_err++; $display("FAIL cnt_wr_magic got %h want ab", m); end
      n_vec++; if (v > 32'd4) begin n_err++; $display("FAIL cnt_restart got %h want <=4", v); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int t = 0;
      logic [7:0] o, e;
      obs_q.delete();
      host_q.push_back(8'hAA); host_q.push_back(8'h01); host_q.push_back(8'h01);
      while (!(host_q.size() == 1 && !nrd_o) && t < 2000) begin @(negedge clk); t++; end
      n_vec++; if (t >= 2000) begin n_err++; $display("FAIL midrst_wait got timeout want read in progress"); end
      do_reset();
      n_vec++; if (nrd_o !== 1'b1) begin n_err++; $display("FAIL midrst_nrd got %b want 1", nrd_o); end
      push_cmd(64'hAA_01_01_00_44_33_22_11); push_reply(32'h11223344);
      wait_obs(5, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_timeout got %0d want 5", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_vec++; if (o !== e) begin n_err++; $display("FAIL midrst_byte got %h want %h", o, e); end
      end
   endtask

   task automatic test_mux_priority();
      bit ok;
      int s0;
      logic [7:0] o, e;
      obs_q.delete();
      s0 = sel_pulses;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin src_mem[0][src_len[0]+i] = 8'h21 + 8'(i); exp_q.push_back(8'h21 + 8'(i)); end
      for (int i = 0; i < 2; i++) src_mem[1][src_len[1]+i] = 8'h31 + 8'(i);
      exp_q.push_back(8'h31); exp_q.push_back(8'h32);
      src_len[0] += 3; src_len[1] += 2;
      wait_obs(5, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL mux_timeout got %0d want 5", obs_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         n_vec++; if (o !== e) begin n_err++; $display("FAIL mux_byte got %h want %h", o, e); end
      end
      repeat (4) @(negedge clk);
      n_vec++; if (sel_pulses !== s0 + 5) begin n_err++; $display("FAIL mux_sel_count got %0d want 5", sel_pulses - s0); end
   endtask

   task automatic test_mux_pause();
      bit ok;
      int n0, p, t = 0;
      logic [7:0] all[$];
      logic [7:0] rep[5];
      logic [7:0] o, e;
      obs_q.delete();
      rep[0] = 8'hAB; rep[1] = 8'hEF; rep[2] = 8'hBE; rep[3] = 8'hED; rep[4] = 8'hFE;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin src_mem[0][src_len[0]+i] = 8'h10 + 8'(i); exp_q.push_back(8'h10 + 8'(i)); end
      src_len[0] += 6;
      while (obs_q.size() < 2 && t < 2000) begin @(negedge clk); t++; end
      n0 = obs_q.size();
      push_cmd(64'hAA_00_02_00_00_00_00_00);
      wait_obs(11, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL pause_timeout got %0d want 11", obs_q.size()); end
      all = obs_q; obs_q.delete();
      p = -1;
      for (int i = 0; i < all.size(); i++) if (p < 0 && all[i] === 8'hAB) p = i;
      n_vec++; if (p < n0 || p - n0 > 2) begin n_err++; $display("FAIL pause_latency got %0d want %0d..%0d", p, n0, n0 + 2); end
      if (p >= 0 && p + 5 <= all.size()) begin
         for (int i = 0; i < 5; i++) begin
            n_vec++; if (all[p+i] !== rep[i]) begin n_err++; $display("FAIL pause_reply got %h want %h", all[p+i], rep[i]); end
         end
         for (int i = 0; i < 5; i++) all.delete(p);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (all.size() > 0) ? all.pop_front() : 8'hxx;
         n_vec++; if (o !== e) begin n_err++; $display("FAIL pause_stream got %h want %h", o, e); end
      end
   endtask

   task automatic test_strobes();
      n_vec++; if (wr_bad !== 0) begin n_err++; $display("FAIL wr_width got %0d bad want 0", wr_bad); end
      n_vec++; if (nrd_bad !== 0) begin n_err++; $display("FAIL nrd_width got %0d bad want 0", nrd_bad); end
      n_vec++; if (si_bad !== 0) begin n_err++; $display("FAIL si_width got %0d bad want 0", si_bad); end
      n_vec++; if (sel_bad !== 0) begin n_err++; $display("FAIL sel_width got %0d bad want 0", sel_bad); end
      n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL rd_wr_overlap got %0d want 0", overlap); end
      n_vec++; if (stab_bad !== 0) begin n_err++; $display("FAIL data_stable got %0d want 0", stab_bad); end
      n_vec++; if (hold_bad !== 0) begin n_err++; $display("FAIL data_hold got %0d want 0", hold_bad); end
      n_vec++; if (wr_pulses == 0) begin n_err++; $display("FAIL wr_activity got %0d want >0", wr_pulses); end
   endtask

   initial begin
      test_reset();
      test_reg_cmds();
      test_counter();
      test_mid_reset();
      test_mux_priority();
      test_mux_pause();
      test_strobes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
